// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issues one ALU operation at a time to the clocked function units and returns the flagged result
module alu_op_sequencer #(
  parameter int LATENCY = 1,
  parameter int NUM_OPS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] fu_a,
  output logic [15:0] fu_b,
  output logic [3:0]  fu_op,
  input  logic [15:0] fu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_neg,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter preload; cnt counts down to 0 and the result is sampled one edge later.
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);
  // Compared against a zero-extended opcode so NUM_OPS=16 accepts every opcode.
  localparam logic [4:0] OP_LIMIT = 5'(NUM_OPS);

  state_t     state;
  logic [3:0] cnt;
  logic       op_legal;

  assign op_legal  = ({1'b0, cmd_op} < OP_LIMIT);

  // Handshake and status outputs depend on the registered state alone.
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  // Sequencer FSM: accept, wait out the unit latency, capture, hold until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      fu_a     <= 16'd0;
      fu_b     <= 16'd0;
      fu_op    <= 4'd0;
      rsp_data <= 16'd0;
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (op_legal) begin
              fu_a  <= cmd_a;
              fu_b  <= cmd_b;
              fu_op <= cmd_op;
              cnt   <= LAT_INIT;
              state <= S_WAIT;
            end else begin
              // Illegal opcode never reaches the units; answer with an error at once.
              rsp_data <= 16'd0;
              rsp_zero <= 1'b0;
              rsp_neg  <= 1'b0;
              rsp_err  <= 1'b1;
              state    <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data <= fu_result;
            rsp_zero <= (fu_result == 16'd0);
            rsp_neg  <= fu_result[15];
            rsp_err  <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          // Return to IDLE only; a waiting command is taken on the next edge.
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer at LATENCY 1 and LATENCY 4
`timescale 1ns/1ps
module tb_alu_op_sequencer;

  localparam int NI      = 2;
  localparam int NUM_OPS = 8;

  typedef struct packed {
    logic [15:0] data;
    logic        zero;
    logic        neg;
    logic        err;
    logic [15:0] fa;
    logic [15:0] fb;
    logic [3:0]  fop;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid [NI];
  logic        cmd_ready [NI];
  logic [3:0]  cmd_op    [NI];
  logic [15:0] cmd_a     [NI];
  logic [15:0] cmd_b     [NI];
  logic [15:0] fu_a      [NI];
  logic [15:0] fu_b      [NI];
  logic [3:0]  fu_op     [NI];
  logic [15:0] fu_result [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [15:0] rsp_data  [NI];
  logic        rsp_zero  [NI];
  logic        rsp_neg   [NI];
  logic        rsp_err   [NI];
  logic        busy      [NI];

  int   n_pass  = 0;
  int   n_total = 0;
  bit   rand_ready = 1'b0;
  rsp_t exp_q0[$];
  rsp_t exp_q1[$];

  logic [15:0] last_a  [NI] = '{16'd0, 16'd0};
  logic [15:0] last_b  [NI] = '{16'd0, 16'd0};
  logic [3:0]  last_op [NI] = '{4'd0, 4'd0};

  logic [15:0] seen_a  [NI] = '{16'd0, 16'd0};
  logic [15:0] seen_b  [NI] = '{16'd0, 16'd0};
  logic [3:0]  seen_op [NI] = '{4'd0, 4'd0};
  logic [3:0]  age     [NI] = '{4'd15, 4'd15};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    alu_op_sequencer #(.LATENCY(g == 0 ? 1 : 4), .NUM_OPS(NUM_OPS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op[g]),
      .cmd_a     (cmd_a[g]),
      .cmd_b     (cmd_b[g]),
      .fu_a      (fu_a[g]),
      .fu_b      (fu_b[g]),
      .fu_op     (fu_op[g]),
      .fu_result (fu_result[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_data  (rsp_data[g]),
      .rsp_zero  (rsp_zero[g]),
      .rsp_neg   (rsp_neg[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [15:0] alu(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      4'd4:    return ~a;
      4'd5:    return a - b;
      4'd6:    return a << b[3:0];
      default: return a >> b[3:0];
    endcase
  endfunction

  function automatic rsp_t model(int k, logic [3:0] op, logic [15:0] a, logic [15:0] b);
    rsp_t        e;
    logic [15:0] r;
    if (int'(op) < NUM_OPS) begin
      r      = alu(op, a, b);
      e.data = r;
      e.zero = (r == 16'd0);
      e.neg  = (r >= 16'h8000);
      e.err  = 1'b0;
      e.fa   = a;
      e.fb   = b;
      e.fop  = op;
    end else begin
      e.data = 16'd0;
      e.zero = 1'b0;
      e.neg  = 1'b0;
      e.err  = 1'b1;
      e.fa   = last_a[k];
      e.fb   = last_b[k];
      e.fop  = last_op[k];
    end
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Clocked function unit: correct result only once operands have been stable for LATENCY edges.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      automatic logic [3:0] na;
      if (fu_a[k] !== seen_a[k] || fu_b[k] !== seen_b[k] || fu_op[k] !== seen_op[k]) na = 4'd1;
      else na = (age[k] == 4'd15) ? 4'd15 : age[k] + 4'd1;
      seen_a[k]  <= fu_a[k];
      seen_b[k]  <= fu_b[k];
      seen_op[k] <= fu_op[k];
      age[k]     <= na;
      if (int'(na) >= lat_of(k)) fu_result[k] <= alu(fu_op[k], fu_a[k], fu_b[k]);
      else fu_result[k] <= 16'($urandom);
    end
  end

  // Scoreboard monitor: every response handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    rsp_t e;
    bit   empty;
    if (rst_n === 1'b1) begin
      for (int k = 0; k < NI; k++) begin
        if (rsp_valid[k] && rsp_ready[k]) begin
          empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
          if (empty) begin
            chk("unexpected_rsp", 64'(rsp_valid[k]), 64'd0);
          end else begin
            if (k == 0) e = exp_q0.pop_front();
            else e = exp_q1.pop_front();
            chk("rsp", {rsp_data[k], rsp_zero[k], rsp_neg[k], rsp_err[k]},
                {e.data, e.zero, e.neg, e.err});
            chk("fu_hold", {fu_a[k], fu_b[k], fu_op[k]}, {e.fa, e.fb, e.fop});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) begin
      for (int k = 0; k < NI; k++) rsp_ready[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic issue(int k, logic [3:0] op, logic [15:0] a, logic [15:0] b, output int waited);
    rsp_t e;
    waited       = 0;
    cmd_op[k]    = op;
    cmd_a[k]     = a;
    cmd_b[k]     = b;
    cmd_valid[k] = 1'b1;
    while (!cmd_ready[k] && waited < 100) begin
      tick();
      waited++;
    end
    if (!cmd_ready[k]) begin
      chk("accept", 64'(cmd_ready[k]), 64'd1);
    end else begin
      e = model(k, op, a, b);
      if (k == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
      if (int'(op) < NUM_OPS) begin
        last_a[k]  = a;
        last_b[k]  = b;
        last_op[k] = op;
      end
      tick();
    end
  endtask

  task automatic await_rsp(int k, bit legal);
    int j;
    j = 0;
    while (!rsp_valid[k] && j < 50) begin
      tick();
      j++;
    end
    chk("latency", 64'(j), legal ? 64'(lat_of(k) + 1) : 64'd0);
  endtask

  task automatic send(int k, logic [3:0] op, logic [15:0] a, logic [15:0] b);
    int w;
    issue(k, op, a, b, w);
    cmd_valid[k] = 1'b0;
    await_rsp(k, int'(op) < NUM_OPS);
  endtask

  task automatic drain(int k);
    int n;
    n = 0;
    while (((k == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", 64'((k == 0) ? exp_q0.size() : exp_q1.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [38:0] snap;
    bit          seen;
    for (int k = 0; k < NI; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_op[k]    = 4'd0;
      cmd_a[k]     = 16'd0;
      cmd_b[k]     = 16'd0;
      rsp_ready[k] = 1'b1;
    end
    rst_n = 1'b0;
    #22;
    for (int k = 0; k < NI; k++)
      chk("reset_state", {fu_a[k], fu_b[k], fu_op[k], rsp_data[k], rsp_zero[k], rsp_neg[k],
                          rsp_err[k], rsp_valid[k], busy[k], cmd_ready[k]},
          {16'd0, 16'd0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    tick();
    rst_n = 1'b1;

    // NOT at LATENCY 1, response lasts exactly one cycle with rsp_ready held high.
    send(0, 4'd4, 16'h00FF, 16'h1357);
    tick();
    chk("one_cycle_valid", 64'(rsp_valid[0]), 64'd0);
    drain(0);

    // AND: zero result, then a masked result.
    send(0, 4'd0, 16'hF0F0, 16'h0F0F);
    drain(0);
    send(0, 4'd0, 16'h1234, 16'h00FF);
    drain(0);

    // Illegal opcodes on both builds, including the last one.
    send(0, 4'd9, 16'hAAAA, 16'h5555);
    drain(0);
    send(1, 4'd15, 16'h1111, 16'h2222);
    drain(1);

    // LATENCY 4: unit drives garbage until E+4, capture must be at E+5.
    send(1, 4'd1, 16'hBEEF, 16'h0000);
    drain(1);

    // Back-pressure with a second command waiting throughout.
    rsp_ready[0] = 1'b0;
    issue(0, 4'd3, 16'h7FFF, 16'h0001, w);
    cmd_op[0] = 4'd5;
    cmd_a[0]  = 16'h0010;
    cmd_b[0]  = 16'h0020;
    await_rsp(0, 1'b1);
    snap = {rsp_valid[0], cmd_ready[0], rsp_data[0], rsp_zero[0], rsp_neg[0], rsp_err[0], fu_a[0]};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {rsp_valid[0], cmd_ready[0], rsp_data[0], rsp_zero[0], rsp_neg[0], rsp_err[0], fu_a[0]},
          {1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h7FFF});
    end
    chk("bp_snapshot", 64'(snap), {25'd0, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 16'h7FFF});
    rsp_ready[0] = 1'b1;
    issue(0, 4'd5, 16'h0010, 16'h0020, w);
    chk("bp_accept_gap", 64'(w), 64'd1);
    cmd_valid[0] = 1'b0;
    await_rsp(0, 1'b1);
    drain(0);

    // Asynchronous reset during WAIT discards the operation.
    issue(1, 4'd2, 16'h1234, 16'h4321, w);
    cmd_valid[1] = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      chk("async_reset", {fu_a[k], fu_b[k], fu_op[k], rsp_data[k], rsp_zero[k], rsp_neg[k],
                          rsp_err[k], rsp_valid[k], busy[k], cmd_ready[k]},
          {16'd0, 16'd0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_q0.delete();
    exp_q1.delete();
    for (int k = 0; k < NI; k++) begin
      last_a[k]  = 16'd0;
      last_b[k]  = 16'd0;
      last_op[k] = 4'd0;
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= rsp_valid[1];
    end
    chk("no_rsp_after_reset", 64'(seen), 64'd0);
    send(1, 4'd3, 16'h0100, 16'h0023);
    drain(1);

    // Random traffic with random consumer back-pressure on both builds.
    rand_ready = 1'b1;
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 30; i++) begin
        send(k, 4'($urandom_range(0, 9)), 16'($urandom), 16'($urandom));
      end
    end
    rand_ready = 1'b0;
    for (int k = 0; k < NI; k++) rsp_ready[k] = 1'b1;
    drain(0);
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
